// File: rtl/pc_gen_if.sv
// Fetch-PC generator bus: redirect sources, halt/fetch handshake and status outputs.
// The master modport is the pc_gen view; the slave modport is the fetch/redirect side.
interface pc_gen_if #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_SRC = 4
);
  logic [NUM_SRC-1:0]      src_valid;
  logic [NUM_SRC*XLEN-1:0] src_pc;
  logic                    halt_req;
  logic                    fetch_ready;
  logic [XLEN-1:0]         pc;
  logic                    pc_valid;
  logic [NUM_SRC-1:0]      src_grant;
  logic [31:0]             redirect_cnt;
  logic                    misalign;

  modport master (
    input  src_valid, src_pc, halt_req, fetch_ready,
    output pc, pc_valid, src_grant, redirect_cnt, misalign
  );

  modport slave (
    output src_valid, src_pc, halt_req, fetch_ready,
    input  pc, pc_valid, src_grant, redirect_cnt, misalign
  );
endinterface

// File: rtl/pc_gen.sv
// Next-PC generator and fetch PC register with prioritised redirects, halt and boot states.
// Optional misaligned-redirect trap is enabled by defining PCGEN_MISALIGN_TRAP_EN.
module pc_gen #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     NUM_SRC  = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     PC_STEP  = 4,
  parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0010
) (
  input  logic     clk,
  input  logic     rst_n,
  pc_gen_if.master bus
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [XLEN-1:0]    pc_q, pc_d;
  logic [XLEN-1:0]    win_pc, target;
  logic [NUM_SRC-1:0] grant;
  logic               found;
  logic               redirect;
  logic [31:0]        cnt_q, cnt_d;

  // Fixed priority: lowest index wins; nothing is granted while booting.
  always_comb begin
    grant  = '0;
    win_pc = '0;
    found  = 1'b0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (!found && bus.src_valid[i]) begin
        grant[i] = 1'b1;
        win_pc   = bus.src_pc[i*XLEN +: XLEN];
        found    = 1'b1;
      end
    end
    if (state_q == ST_BOOT) begin
      grant = '0;
    end
  end

  assign redirect = |grant;

`ifdef PCGEN_MISALIGN_TRAP_EN
  logic bad_align;
  logic misalign_q;

  assign bad_align = (win_pc[1:0] != 2'b00);
  assign target    = bad_align ? TRAP_VEC : win_pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= redirect && bad_align;
    end
  end

  assign bus.misalign = misalign_q;
`else
  logic [XLEN-1:0] unused_trap_vec;

  assign unused_trap_vec = TRAP_VEC;
  assign target          = win_pc & ~XLEN'(3);
  assign bus.misalign    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      // A redirect in the same cycle defers entry into HALT by one cycle.
      ST_RUN:  if (bus.halt_req && !redirect) state_d = ST_HALT;
      ST_HALT: if (!bus.halt_req) state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = target;
    end else if ((state_q == ST_RUN) && bus.fetch_ready) begin
      pc_d = pc_q + XLEN'(PC_STEP);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (redirect && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.pc           = pc_q;
  assign bus.pc_valid     = (state_q == ST_RUN);
  assign bus.src_grant    = grant;
  assign bus.redirect_cnt = cnt_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: expectations queued at stimulus time, checked after each edge.
module tb_pc_gen;

  typedef struct packed {
    logic [31:0] pc;
    logic        valid;
    logic [31:0] cnt;
    logic        mis;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] spc [4];
  int          n_tests;
  int          n_fail;
  int          step_id;
  exp_t        exp_q[$];

  pc_gen_if #(.XLEN(32), .NUM_SRC(4)) bus ();

  pc_gen #(
    .XLEN     (32),
    .NUM_SRC  (4),
    .RESET_PC (32'h0000_0000),
    .PC_STEP  (4),
    .TRAP_VEC (32'h0000_0010)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.src_pc = {spc[3], spc[2], spc[1], spc[0]};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge: apply inputs, check the combinational grant, queue the
  // expected post-edge state, then compare it once the DUT has clocked.
  task automatic drive(input logic [3:0] sv, input logic halt, input logic fr,
                       input logic [3:0] e_grant, input logic [31:0] e_pc,
                       input logic e_valid, input logic [31:0] e_cnt, input logic e_mis);
    exp_t e;
    exp_t o;
    step_id++;
    bus.src_valid   = sv;
    bus.halt_req    = halt;
    bus.fetch_ready = fr;
    #1;
    check($sformatf("grant#%0d", step_id), 64'(bus.src_grant), 64'(e_grant));
    e.pc    = e_pc;
    e.valid = e_valid;
    e.cnt   = e_cnt;
    e.mis   = e_mis;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    o = exp_q.pop_front();
    check($sformatf("pc#%0d", step_id), 64'(bus.pc), 64'(o.pc));
    check($sformatf("valid#%0d", step_id), 64'(bus.pc_valid), 64'(o.valid));
    check($sformatf("cnt#%0d", step_id), 64'(bus.redirect_cnt), 64'(o.cnt));
    check($sformatf("mis#%0d", step_id), 64'(bus.misalign), 64'(o.mis));
    @(negedge clk);
  endtask

  initial begin
    n_tests         = 0;
    n_fail          = 0;
    step_id         = 0;
    rst_n           = 1'b0;
    bus.src_valid   = '0;
    bus.halt_req    = 1'b0;
    bus.fetch_ready = 1'b0;
    for (int i = 0; i < 4; i++) spc[i] = '0;

    @(posedge clk);
    #1;
    check("rst_pc", 64'(bus.pc), 64'h0);
    check("rst_valid", 64'(bus.pc_valid), 64'h0);
    check("rst_cnt", 64'(bus.redirect_cnt), 64'h0);
    check("rst_mis", 64'(bus.misalign), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Boot: a source request is ignored, then sequential fetch.
    spc[0] = 32'h0000_0500;
    drive(4'b0001, 1'b0, 1'b1, 4'b0000, 32'h0, 1'b1, 32'd0, 1'b0);
    drive(4'b0000, 1'b0, 1'b1, 4'b0000, 32'h4, 1'b1, 32'd0, 1'b0);
    drive(4'b0000, 1'b0, 1'b1, 4'b0000, 32'h8, 1'b1, 32'd0, 1'b0);

    // Fetch stalls hold the pc.
    for (int i = 0; i < 3; i++) begin
      drive(4'b0000, 1'b0, 1'b0, 4'b0000, 32'h8, 1'b1, 32'd0, 1'b0);
    end

    // Priority: source 1 beats source 2.
    spc[1] = 32'h0000_0100;
    spc[2] = 32'h0000_0200;
    drive(4'b0110, 1'b0, 1'b0, 4'b0010, 32'h100, 1'b1, 32'd1, 1'b0);

    // Redirect with accept, then wrap, then redirect beats increment.
    spc[0] = 32'hFFFF_FFFC;
    drive(4'b0001, 1'b0, 1'b1, 4'b0001, 32'hFFFF_FFFC, 1'b1, 32'd2, 1'b0);
    drive(4'b0000, 1'b0, 1'b1, 4'b0000, 32'h0, 1'b1, 32'd2, 1'b0);
    spc[3] = 32'h0000_0300;
    drive(4'b1000, 1'b0, 1'b1, 4'b1000, 32'h300, 1'b1, 32'd3, 1'b0);

    // Halt: last accepted fetch increments, redirect while halted, resume.
    drive(4'b0000, 1'b1, 1'b1, 4'b0000, 32'h304, 1'b0, 32'd3, 1'b0);
    spc[2] = 32'h0000_0040;
    drive(4'b0100, 1'b1, 1'b1, 4'b0100, 32'h40, 1'b0, 32'd4, 1'b0);
    drive(4'b0000, 1'b1, 1'b1, 4'b0000, 32'h40, 1'b0, 32'd4, 1'b0);
    drive(4'b0000, 1'b0, 1'b0, 4'b0000, 32'h40, 1'b1, 32'd4, 1'b0);
    drive(4'b0000, 1'b0, 1'b1, 4'b0000, 32'h44, 1'b1, 32'd4, 1'b0);

    // Redirect with halt_req in RUN stays in RUN for that cycle.
    spc[0] = 32'h0000_0080;
    drive(4'b0001, 1'b1, 1'b0, 4'b0001, 32'h80, 1'b1, 32'd5, 1'b0);
    drive(4'b0000, 1'b1, 1'b1, 4'b0000, 32'h84, 1'b0, 32'd5, 1'b0);
    drive(4'b0000, 1'b0, 1'b0, 4'b0000, 32'h84, 1'b1, 32'd5, 1'b0);

    // Misaligned redirect.
    spc[1] = 32'h0000_0102;
`ifdef PCGEN_MISALIGN_TRAP_EN
    drive(4'b0010, 1'b0, 1'b0, 4'b0010, 32'h10, 1'b1, 32'd6, 1'b1);
    drive(4'b0000, 1'b0, 1'b0, 4'b0000, 32'h10, 1'b1, 32'd6, 1'b0);
`else
    drive(4'b0010, 1'b0, 1'b0, 4'b0010, 32'h100, 1'b1, 32'd6, 1'b0);
    drive(4'b0000, 1'b0, 1'b0, 4'b0000, 32'h100, 1'b1, 32'd6, 1'b0);
`endif

    // Mid-run reset discards a pending redirect, then boots again.
    rst_n  = 1'b0;
    spc[0] = 32'h0000_0700;
    drive(4'b0001, 1'b0, 1'b1, 4'b0001, 32'h0, 1'b0, 32'd0, 1'b0);
    rst_n = 1'b1;
    drive(4'b0000, 1'b0, 1'b1, 4'b0000, 32'h0, 1'b1, 32'd0, 1'b0);
    drive(4'b0000, 1'b0, 1'b1, 4'b0000, 32'h4, 1'b1, 32'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
